// File: rtl/mem_stage_vlat.sv
// MEM pipeline stage for a variable-latency data bus.
// Holds one instruction and waits for its in-order bus response, which may
// also arrive in the same cycle it is needed. Responses that belong to
// instructions killed by a flush are counted and dropped. Load data is
// aligned and extended here before it goes to WB.
module mem_stage_vlat #(
   parameter int SIDE_W      = 64,
   parameter int MAX_DISCARD = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              es_to_ms_valid,
   input  logic              es_req_sent,
   input  logic [2:0]        es_load_op,
   input  logic [1:0]        es_addr_lo,
   input  logic [31:0]       es_alu_result,
   input  logic [31:0]       es_rt_value,
   input  logic              es_ex,
   input  logic [SIDE_W-1:0] es_side,
   output logic              ms_allowin,
   input  logic              data_ok,
   input  logic [31:0]       data_rdata,
   input  logic              ws_allowin,
   output logic              ms_to_ws_valid,
   output logic [31:0]       ms_result,
   output logic              ms_ex,
   output logic [SIDE_W-1:0] ms_side,
   output logic              ms_fwd_valid,
   output logic              ms_load_stall,
   input  logic              flush
);

   localparam int CNT_W = $clog2(MAX_DISCARD + 1);

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_W    = 3'd1,
      LD_H    = 3'd2,
      LD_HU   = 3'd3,
      LD_B    = 3'd4,
      LD_BU   = 3'd5,
      LD_WL   = 3'd6,
      LD_WR   = 3'd7
   } load_op_e;

   logic              ms_valid_q, ms_valid_d;
   logic              ms_req_q;
   logic              resp_got_q, resp_got_d;
   logic [CNT_W-1:0]  discard_cnt_q, discard_cnt_d;
   logic [31:0]       rdata_buf_q, rdata_buf_d;
   load_op_e          op_q;
   logic [1:0]        addr_lo_q;
   logic [31:0]       alu_q;
   logic [31:0]       rt_q;
   logic              ex_q;
   logic [SIDE_W-1:0] side_q;

   logic              no_discard;
   logic              resp_bypass;
   logic              ms_ready_go;
   logic              capture;
   logic              advance;
   logic              resp_accept;
   logic              resp_drop;
   logic              discard_inc;

   logic [31:0]       ld_data;
   logic [15:0]       ld_half;
   logic [7:0]        ld_byte;

   // A response with no killed ones ahead of it belongs to the held instruction.
   assign no_discard     = (discard_cnt_q == '0);
   assign resp_bypass    = data_ok && no_discard;
   assign ms_ready_go    = !ms_req_q || resp_got_q || resp_bypass;
   assign ms_allowin     = (!ms_valid_q || (ms_ready_go && ws_allowin)) &&
                           (discard_cnt_q < CNT_W'(MAX_DISCARD));
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
   assign capture        = es_to_ms_valid && ms_allowin && !flush;
   assign advance        = ms_to_ws_valid && ws_allowin;
   assign resp_drop      = data_ok && !no_discard;
   assign resp_accept    = resp_bypass && ms_valid_q && ms_req_q && !resp_got_q;
   assign discard_inc    = flush && ms_valid_q && ms_req_q && !resp_got_q && !resp_bypass;

   assign ms_ex          = ex_q;
   assign ms_side        = side_q;
   assign ms_fwd_valid   = ms_valid_q && ms_ready_go;
   assign ms_load_stall  = ms_valid_q && (op_q != LD_NONE) && !ms_ready_go;

   // Next-state for occupancy, response tracking and the discard counter.
   always_comb begin
      ms_valid_d    = ms_valid_q;
      resp_got_d    = resp_got_q;
      rdata_buf_d   = rdata_buf_q;
      discard_cnt_d = discard_cnt_q;
      if (resp_accept) begin
         resp_got_d  = 1'b1;
         rdata_buf_d = data_rdata;
      end
      if (flush) begin
         ms_valid_d = 1'b0;
         resp_got_d = 1'b0;
      end else if (capture) begin
         ms_valid_d = 1'b1;
         resp_got_d = 1'b0;
      end else if (advance) begin
         ms_valid_d = 1'b0;
         resp_got_d = 1'b0;
      end
      // A kill and a dropped response in the same cycle cancel out.
      case ({discard_inc, resp_drop})
         2'b10:   discard_cnt_d = discard_cnt_q + CNT_W'(1);
         2'b01:   discard_cnt_d = discard_cnt_q - CNT_W'(1);
         default: discard_cnt_d = discard_cnt_q;
      endcase
   end

   // State registers and capture of the incoming instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid_q    <= 1'b0;
         ms_req_q      <= 1'b0;
         resp_got_q    <= 1'b0;
         discard_cnt_q <= '0;
         rdata_buf_q   <= '0;
         op_q          <= LD_NONE;
         addr_lo_q     <= '0;
         alu_q         <= '0;
         rt_q          <= '0;
         ex_q          <= 1'b0;
         side_q        <= '0;
      end else begin
         ms_valid_q    <= ms_valid_d;
         resp_got_q    <= resp_got_d;
         discard_cnt_q <= discard_cnt_d;
         rdata_buf_q   <= rdata_buf_d;
         if (capture) begin
            ms_req_q  <= es_req_sent;
            op_q      <= load_op_e'(es_load_op);
            addr_lo_q <= es_addr_lo;
            alu_q     <= es_alu_result;
            rt_q      <= es_rt_value;
            ex_q      <= es_ex;
            side_q    <= es_side;
         end
      end
   end

   // Load alignment/extension; a same-cycle response bypasses the buffer.
   always_comb begin
      ld_data = resp_got_q ? rdata_buf_q : data_rdata;
      ld_half = addr_lo_q[1] ? ld_data[31:16] : ld_data[15:0];
      case (addr_lo_q)
         2'd0:    ld_byte = ld_data[7:0];
         2'd1:    ld_byte = ld_data[15:8];
         2'd2:    ld_byte = ld_data[23:16];
         default: ld_byte = ld_data[31:24];
      endcase
      ms_result = alu_q;
      case (op_q)
         LD_W:  ms_result = ld_data;
         LD_H:  ms_result = {{16{ld_half[15]}}, ld_half};
         LD_HU: ms_result = {16'h0000, ld_half};
         LD_B:  ms_result = {{24{ld_byte[7]}}, ld_byte};
         LD_BU: ms_result = {24'h000000, ld_byte};
         LD_WL: begin
            case (addr_lo_q)
               2'd0:    ms_result = {ld_data[7:0],  rt_q[23:0]};
               2'd1:    ms_result = {ld_data[15:0], rt_q[15:0]};
               2'd2:    ms_result = {ld_data[23:0], rt_q[7:0]};
               default: ms_result = ld_data;
            endcase
         end
         LD_WR: begin
            case (addr_lo_q)
               2'd0:    ms_result = ld_data;
               2'd1:    ms_result = {rt_q[31:24], ld_data[31:8]};
               2'd2:    ms_result = {rt_q[31:16], ld_data[31:16]};
               default: ms_result = {rt_q[31:8],  ld_data[31:24]};
            endcase
         end
         default: ms_result = alu_q;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_vlat.sv
// Bench for mem_stage_vlat: directed scenarios followed by random traffic,
// all checked against a queue-based model of the bus and the stage.
module tb_mem_stage_vlat;
   localparam int SIDE_W      = 64;
   localparam int MAX_DISCARD = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              es_to_ms_valid;
   logic              es_req_sent;
   logic [2:0]        es_load_op;
   logic [1:0]        es_addr_lo;
   logic [31:0]       es_alu_result;
   logic [31:0]       es_rt_value;
   logic              es_ex;
   logic [SIDE_W-1:0] es_side;
   logic              ms_allowin;
   logic              data_ok;
   logic [31:0]       data_rdata;
   logic              ws_allowin;
   logic              ms_to_ws_valid;
   logic [31:0]       ms_result;
   logic              ms_ex;
   logic [SIDE_W-1:0] ms_side;
   logic              ms_fwd_valid;
   logic              ms_load_stall;
   logic              flush;

   always #5 clk = ~clk;

   mem_stage_vlat #(.SIDE_W(SIDE_W), .MAX_DISCARD(MAX_DISCARD)) dut (
      .clk(clk), .reset(reset),
      .es_to_ms_valid(es_to_ms_valid), .es_req_sent(es_req_sent),
      .es_load_op(es_load_op), .es_addr_lo(es_addr_lo),
      .es_alu_result(es_alu_result), .es_rt_value(es_rt_value),
      .es_ex(es_ex), .es_side(es_side), .ms_allowin(ms_allowin),
      .data_ok(data_ok), .data_rdata(data_rdata), .ws_allowin(ws_allowin),
      .ms_to_ws_valid(ms_to_ws_valid), .ms_result(ms_result), .ms_ex(ms_ex),
      .ms_side(ms_side), .ms_fwd_valid(ms_fwd_valid),
      .ms_load_stall(ms_load_stall), .flush(flush)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: the held instruction plus a queue of outstanding bus
   // requests in issue order (1 = owner was killed, 0 = owner still live).
   bit          m_valid, m_req, m_got, m_ex;
   logic [2:0]  m_op;
   logic [1:0]  m_a;
   logic [31:0] m_alu, m_rt, m_data;
   logic [63:0] m_side;
   bit          outst[$];
   bit          e_ready, e_allowin, e_tows, e_fwd, e_stall;
   logic [31:0] e_result;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, 64'(obs), 64'(exp));
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk(tag, 64'(obs), 64'(exp));
   endtask

   function automatic int killed_cnt();
      int n = 0;
      foreach (outst[i]) if (outst[i]) n++;
      return n;
   endfunction

   function automatic logic [31:0] align(input logic [2:0] op, input logic [1:0] a,
                                         input logic [31:0] d, input logic [31:0] rt);
      int unsigned sh;
      logic [31:0] lane;
      sh = 8 * a;
      case (op)
         3'd1: return d;
         3'd2: begin
            lane = (d >> (16 * a[1])) & 32'h0000FFFF;
            return lane[15] ? (lane | 32'hFFFF0000) : lane;
         end
         3'd3: return (d >> (16 * a[1])) & 32'h0000FFFF;
         3'd4: begin
            lane = (d >> sh) & 32'h000000FF;
            return lane[7] ? (lane | 32'hFFFFFF00) : lane;
         end
         3'd5: return (d >> sh) & 32'h000000FF;
         3'd6: return (d << (24 - sh)) | (rt & (32'h00FFFFFF >> sh));
         3'd7: return (d >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_eval();
      bit head_live;
      head_live = (outst.size() > 0) && !outst[0];
      e_ready   = !m_req || m_got || (data_ok && head_live);
      e_allowin = (!m_valid || (e_ready && ws_allowin)) && (killed_cnt() < MAX_DISCARD);
      e_tows    = m_valid && e_ready && !flush;
      e_fwd     = m_valid && e_ready;
      e_stall   = m_valid && (m_op != 3'd0) && !e_ready;
      e_result  = (m_op == 3'd0) ? m_alu : align(m_op, m_a, m_got ? m_data : data_rdata, m_rt);
   endtask

   // Inputs are already driven (just after a falling edge); compare outputs.
   task automatic settle(input string ph);
      #1;
      model_eval();
      chk1({ph, ".allowin"}, ms_allowin, e_allowin);
      chk1({ph, ".to_ws"}, ms_to_ws_valid, e_tows);
      chk1({ph, ".fwd"}, ms_fwd_valid, e_fwd);
      chk1({ph, ".stall"}, ms_load_stall, e_stall);
      if (m_valid) begin
         chk1({ph, ".ex"}, ms_ex, m_ex);
         chk({ph, ".side"}, ms_side, m_side);
      end
      if (e_fwd) chk32({ph, ".result"}, ms_result, e_result);
   endtask

   // Advance the model by one clock using the current inputs, then move to the next falling edge.
   task automatic tick();
      bit was_live;
      if (data_ok && outst.size() > 0) begin
         was_live = !outst[0];
         void'(outst.pop_front());
         if (was_live) begin
            m_got  = 1'b1;
            m_data = data_rdata;
         end
      end
      if (flush) begin
         if (m_valid && m_req && !m_got)
            foreach (outst[i]) if (!outst[i]) outst[i] = 1'b1;
         m_valid = 1'b0;
         m_got   = 1'b0;
      end else begin
         if (e_tows && ws_allowin) begin
            m_valid = 1'b0;
            m_got   = 1'b0;
         end
         if (es_to_ms_valid && e_allowin) begin
            m_valid = 1'b1;
            m_got   = 1'b0;
            m_req   = es_req_sent;
            m_op    = es_load_op;
            m_a     = es_addr_lo;
            m_alu   = es_alu_result;
            m_rt    = es_rt_value;
            m_ex    = es_ex;
            m_side  = es_side;
            if (es_req_sent) outst.push_back(1'b0);
         end
      end
      @(negedge clk);
   endtask

   task automatic cyc(input string ph);
      settle(ph);
      tick();
   endtask

   task automatic idle();
      es_to_ms_valid = 1'b0;
      es_req_sent    = 1'b0;
      data_ok        = 1'b0;
      flush          = 1'b0;
      ws_allowin     = 1'b1;
      data_rdata     = $urandom;
   endtask

   task automatic offer(input logic [2:0] op, input logic [1:0] a, input logic [31:0] rt,
                        input logic req);
      es_to_ms_valid = 1'b1;
      es_req_sent    = req;
      es_load_op     = op;
      es_addr_lo     = a;
      es_alu_result  = $urandom;
      es_rt_value    = rt;
      es_ex          = 1'b0;
      es_side        = {$urandom, $urandom};
   endtask

   // Capture a load, then answer it on the very next cycle and check the result.
   task automatic load_now(input string ph, input logic [2:0] op, input logic [1:0] a,
                           input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] expv);
      idle();
      offer(op, a, rt, 1'b1);
      cyc({ph, ".cap"});
      idle();
      data_ok    = 1'b1;
      data_rdata = rd;
      settle(ph);
      chk32({ph, ".value"}, ms_result, expv);
      chk1({ph, ".valid"}, ms_to_ws_valid, 1'b1);
      chk1({ph, ".nostall"}, ms_load_stall, 1'b0);
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit hold;
      bit req;
      bit ex;
      logic [2:0] op;

      reset = 1'b1;
      idle();
      offer(3'd0, 2'd0, 32'h0, 1'b0);
      es_to_ms_valid = 1'b0;
      m_valid = 0; m_req = 0; m_got = 0; m_ex = 0;
      m_op = '0; m_a = '0; m_alu = '0; m_rt = '0; m_data = '0; m_side = '0;
      repeat (3) @(negedge clk);
      #1;
      chk1("rst.to_ws", ms_to_ws_valid, 1'b0);
      chk1("rst.fwd", ms_fwd_valid, 1'b0);
      chk1("rst.stall", ms_load_stall, 1'b0);
      chk1("rst.ex", ms_ex, 1'b0);
      chk32("rst.result", ms_result, 32'h0);
      chk("rst.side", ms_side, 64'h0);
      chk1("rst.allowin", ms_allowin, 1'b1);
      @(negedge clk);
      reset = 1'b0;

      load_now("lw0",  3'd1, 2'd0, $urandom,     32'h8765_4321, 32'h8765_4321);
      load_now("lb3",  3'd4, 2'd3, $urandom,     32'h8012_3456, 32'hFFFF_FF80);
      load_now("lbu3", 3'd5, 2'd3, $urandom,     32'h8012_3456, 32'h0000_0080);
      load_now("lh2",  3'd2, 2'd2, $urandom,     32'h8001_5678, 32'hFFFF_8001);
      load_now("lwl1", 3'd6, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
      load_now("lwr2", 3'd7, 2'd2, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB);

      // Late response, then back-pressure from WB while the data is buffered.
      idle(); offer(3'd1, 2'd0, $urandom, 1'b1); cyc("late.cap");
      for (int i = 0; i < 2; i++) begin
         idle(); settle("late.wait");
         chk1("late.stall", ms_load_stall, 1'b1);
         chk1("late.block", ms_allowin, 1'b0);
         tick();
      end
      idle(); ws_allowin = 1'b0; data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
      settle("late.resp");
      chk32("late.value", ms_result, 32'hCAFE_F00D);
      tick();
      idle(); ws_allowin = 1'b0; data_rdata = 32'h1234_5678;
      settle("late.held");
      chk32("late.held_value", ms_result, 32'hCAFE_F00D);
      chk1("late.held_valid", ms_to_ws_valid, 1'b1);
      tick();
      idle(); settle("late.release");
      chk32("late.release_value", ms_result, 32'hCAFE_F00D);
      tick();

      // Flush with a load outstanding: its response must be dropped.
      idle(); offer(3'd1, 2'd0, $urandom, 1'b1); cyc("fl.cap");
      idle(); flush = 1'b1; settle("fl.flush");
      chk1("fl.no_valid", ms_to_ws_valid, 1'b0);
      tick();
      idle(); offer(3'd1, 2'd0, $urandom, 1'b1); settle("fl.cap2");
      chk1("fl.allowin", ms_allowin, 1'b1);
      tick();
      idle(); data_ok = 1'b1; data_rdata = 32'h0000_DEAD; settle("fl.drop");
      chk1("fl.drop_stall", ms_load_stall, 1'b1);
      tick();
      idle(); data_ok = 1'b1; data_rdata = 32'h0000_BEEF; settle("fl.deliver");
      chk32("fl.value", ms_result, 32'h0000_BEEF);
      chk1("fl.valid", ms_to_ws_valid, 1'b1);
      tick();

      // Fill the discard tracker, then a flush coinciding with a dropped response.
      for (int i = 0; i < MAX_DISCARD; i++) begin
         idle(); offer(3'd1, 2'd0, $urandom, 1'b1); cyc("full.cap");
         idle(); flush = 1'b1; cyc("full.flush");
      end
      idle(); offer(3'd1, 2'd0, $urandom, 1'b1); settle("full.blocked");
      chk1("full.allowin", ms_allowin, 1'b0);
      tick();
      idle(); data_ok = 1'b1; settle("full.pop");
      chk1("full.pop_allowin", ms_allowin, 1'b0);
      tick();
      idle(); settle("full.open");
      chk1("full.open_allowin", ms_allowin, 1'b1);
      tick();
      idle(); data_ok = 1'b1; cyc("full.pop2");
      idle(); offer(3'd1, 2'd0, $urandom, 1'b1); cyc("net.cap");
      idle(); flush = 1'b1; data_ok = 1'b1; cyc("net.flush");
      idle(); offer(3'd1, 2'd0, $urandom, 1'b1); cyc("net.cap2");
      idle(); data_ok = 1'b1; data_rdata = 32'h1111_1111; settle("net.drop");
      chk1("net.drop_stall", ms_load_stall, 1'b1);
      tick();
      idle(); data_ok = 1'b1; data_rdata = 32'h2222_3333; settle("net.deliver");
      chk32("net.value", ms_result, 32'h2222_3333);
      tick();

      // Random traffic.
      hold = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         flush      = ($urandom_range(0, 15) == 0);
         ws_allowin = ($urandom_range(0, 3) != 0);
         data_ok    = (outst.size() > 0) && ($urandom_range(0, 2) == 0);
         data_rdata = $urandom;
         if (!hold) begin
            if ($urandom_range(0, 2) != 0) begin
               op  = 3'($urandom_range(0, 7));
               ex  = ($urandom_range(0, 9) == 0);
               req = !ex && ((op != 3'd0) || ($urandom_range(0, 1) == 1));
               offer(op, 2'($urandom_range(0, 3)), $urandom, req);
               es_ex = ex;
               hold  = 1'b1;
            end else begin
               es_to_ms_valid = 1'b0;
            end
         end
         settle("rnd");
         if (flush || (es_to_ms_valid && e_allowin)) hold = 1'b0;
         tick();
         if (!hold) es_to_ms_valid = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
